// File: rtl/psum_collector_pkg.sv
// rtl/psum_collector_pkg.sv - shared types and sizing for the psum collector
package psum_collector_pkg;

  localparam int LANES   = 4;
  localparam int PSUMDWD = 16;
  localparam int ODWD    = 8;
  localparam int DEPTH   = 8;
  localparam int MAXPASS = 16;

  // Sized so MAXPASS full-scale psums never wrap.
  localparam int ACCWD   = PSUMDWD + $clog2(MAXPASS);
  localparam int PTRWD   = $clog2(DEPTH);
  localparam int PASSCW  = $clog2(MAXPASS);
  localparam int LENWD   = PTRWD + 1;
  localparam int PASSWD  = PASSCW + 1;
  localparam int SHIFTWD = 4;

  typedef struct packed {
    logic [LENWD-1:0]   len;
    logic [PASSWD-1:0]  passes;
    logic [SHIFTWD-1:0] shift;
    logic               relu;
  } PostConf;

  typedef enum logic [1:0] {IDLE, ACC, DRAIN} PCstate;

  function automatic PostConf clamp_cfg(input PostConf c);
    PostConf r;
    r = c;
    if (c.len == '0) r.len = LENWD'(1);
    else if (c.len > LENWD'(DEPTH)) r.len = LENWD'(DEPTH);
    if (c.passes == '0) r.passes = PASSWD'(1);
    else if (c.passes > PASSWD'(MAXPASS)) r.passes = PASSWD'(MAXPASS);
    return r;
  endfunction

endpackage

// File: rtl/psum_post.sv
// rtl/psum_post.sv - per-lane ReLU, arithmetic shift and saturation
module psum_post
  import psum_collector_pkg::*;
(
  input  logic signed [ACCWD-1:0]   x,
  input  logic        [SHIFTWD-1:0] shift,
  input  logic                      relu,
  output logic        [ODWD-1:0]    y
);

  localparam logic signed [ACCWD-1:0] SAT_HI = {{(ACCWD-ODWD+1){1'b0}}, {(ODWD-1){1'b1}}};
  localparam logic signed [ACCWD-1:0] SAT_LO = {{(ACCWD-ODWD+1){1'b1}}, {(ODWD-1){1'b0}}};

  logic signed [ACCWD-1:0] rect;
  logic signed [ACCWD-1:0] shifted;

  always_comb begin
    rect    = (relu && x < 0) ? '0 : x;
    shifted = rect >>> shift;
    if (shifted > SAT_HI)      y = SAT_HI[ODWD-1:0];
    else if (shifted < SAT_LO) y = SAT_LO[ODWD-1:0];
    else                       y = shifted[ODWD-1:0];
  end

endmodule

// File: rtl/psum_collector.sv
// rtl/psum_collector.sv - multi-pass psum accumulator with post-processing drain
module psum_collector
  import psum_collector_pkg::*;
(
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_cfg_valid,
  input  PostConf                        i_cfg,
  input  logic                           Psum_rdy,
  output logic                           Psum_ack,
  input  logic [LANES-1:0][PSUMDWD-1:0]  i_Psum,
  output logic                           Out_rdy,
  input  logic                           Out_ack,
  output logic [LANES-1:0][ODWD-1:0]     o_Out,
  output logic                           o_busy,
  output logic                           o_done
);

  PCstate                        state, next;
  PostConf                       cfg_r;
  logic [PTRWD-1:0]              wptr, rptr;
  logic [PASSCW-1:0]             pass;
  logic [LANES-1:0][ACCWD-1:0]   acc_buf [DEPTH];

  logic psum_fire, out_fire, w_last, r_last, pass_last;
  logic [LENWD-1:0]  len_m1;
  logic [PASSWD-1:0] passes_m1;

  assign len_m1    = cfg_r.len - LENWD'(1);
  assign passes_m1 = cfg_r.passes - PASSWD'(1);
  assign w_last    = ({1'b0, wptr} == len_m1);
  assign r_last    = ({1'b0, rptr} == len_m1);
  assign pass_last = ({1'b0, pass} == passes_m1);
  assign psum_fire = Psum_rdy & Psum_ack;
  assign out_fire  = Out_rdy & Out_ack;
  assign o_busy    = (state != IDLE);

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= next;
  end

  always_comb begin
    next     = state;
    Psum_ack = 1'b0;
    Out_rdy  = 1'b0;
    case (state)
      IDLE:  if (i_cfg_valid) next = ACC;
      ACC: begin
        Psum_ack = 1'b1;
        if (psum_fire && w_last && pass_last) next = DRAIN;
      end
      DRAIN: begin
        Out_rdy = 1'b1;
        if (out_fire && r_last) next = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cfg_r.len    <= LENWD'(1);
      cfg_r.passes <= PASSWD'(1);
      cfg_r.shift  <= '0;
      cfg_r.relu   <= 1'b0;
      wptr         <= '0;
      rptr         <= '0;
      pass         <= '0;
      o_done       <= 1'b0;
      for (int d = 0; d < DEPTH; d++) acc_buf[d] <= '0;
    end else begin
      o_done <= (state == DRAIN) && out_fire && r_last;
      case (state)
        IDLE: begin
          if (i_cfg_valid) cfg_r <= clamp_cfg(i_cfg);
          wptr <= '0;
          rptr <= '0;
          pass <= '0;
        end
        ACC: begin
          if (psum_fire) begin
            // First pass overwrites so stale data from a previous job never leaks in.
            for (int l = 0; l < LANES; l++) begin
              acc_buf[wptr][l] <= ((pass == '0) ? '0 : acc_buf[wptr][l])
                                  + {{(ACCWD-PSUMDWD){i_Psum[l][PSUMDWD-1]}}, i_Psum[l]};
            end
            if (w_last) begin
              wptr <= '0;
              pass <= pass + PASSCW'(1);
            end else begin
              wptr <= wptr + PTRWD'(1);
            end
          end
          rptr <= '0;
        end
        DRAIN: if (out_fire) rptr <= rptr + PTRWD'(1);
        default: ;
      endcase
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_post
    psum_post u_post (
      .x     (acc_buf[rptr][l]),
      .shift (cfg_r.shift),
      .relu  (cfg_r.relu),
      .y     (o_Out[l])
    );
  end

endmodule

// File: tb/tb_psum_collector.sv
// tb/tb_psum_collector.sv - scoreboard bench for psum_collector
module tb_psum_collector;
  import psum_collector_pkg::*;

  typedef logic [LANES-1:0][PSUMDWD-1:0] psum_t;
  typedef logic [LANES-1:0][ODWD-1:0]    out_t;

  logic    i_clk, i_rst, i_cfg_valid, Psum_rdy, Psum_ack, Out_rdy, Out_ack, o_busy, o_done;
  PostConf i_cfg;
  psum_t   i_Psum;
  out_t    o_Out;

  int   checks = 0, errors = 0;
  int   done_cnt = 0, done_exp = 0, psum_cnt = 0, ack_mode = 0;
  out_t exp_q[$];
  out_t mon_e, prev_out;
  logic prev_hold = 1'b0;

  psum_collector dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_cfg_valid(i_cfg_valid), .i_cfg(i_cfg),
    .Psum_rdy(Psum_rdy), .Psum_ack(Psum_ack), .i_Psum(i_Psum),
    .Out_rdy(Out_rdy), .Out_ack(Out_ack), .o_Out(o_Out),
    .o_busy(o_busy), .o_done(o_done)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic PostConf mk_cfg(input int len, input int passes, input int shift, input int relu);
    PostConf c;
    c.len    = LENWD'(len);
    c.passes = PASSWD'(passes);
    c.shift  = SHIFTWD'(shift);
    c.relu   = relu[0];
    return c;
  endfunction

  function automatic psum_t mkp(input int a, input int b, input int c, input int d);
    psum_t r;
    r[0] = PSUMDWD'(a); r[1] = PSUMDWD'(b); r[2] = PSUMDWD'(c); r[3] = PSUMDWD'(d);
    return r;
  endfunction

  function automatic out_t mko(input int a, input int b, input int c, input int d);
    out_t r;
    r[0] = ODWD'(a); r[1] = ODWD'(b); r[2] = ODWD'(c); r[3] = ODWD'(d);
    return r;
  endfunction

  initial begin
    Out_ack = 1'b1;
    forever begin
      @(posedge i_clk);
      #1;
      case (ack_mode)
        0:       Out_ack = 1'b1;
        1:       Out_ack = 1'($urandom_range(0, 1));
        default: Out_ack = 1'b0;
      endcase
    end
  end

  always @(negedge i_clk) begin
    if (i_rst) begin
      prev_hold = 1'b0;
    end else begin
      if (o_done) done_cnt++;
      if (Psum_rdy && Psum_ack) psum_cnt++;
      if (Out_rdy) chk("psum_ack_in_drain", 64'(Psum_ack), 64'd0);
      if (prev_hold && Out_rdy) chk("out_stable", 64'(o_Out), 64'(prev_out));
      if (Out_rdy && Out_ack) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got %0h expected no beat", o_Out);
        end else begin
          mon_e = exp_q.pop_front();
          chk("out_beat", 64'(o_Out), 64'(mon_e));
        end
      end
      prev_hold = Out_rdy && !Out_ack;
      prev_out  = o_Out;
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_cfg(input PostConf c);
    i_cfg_valid = 1'b1;
    i_cfg       = c;
    tick();
    i_cfg_valid = 1'b0;
  endtask

  task automatic send(input psum_t d);
    int n = 0;
    Psum_rdy = 1'b1;
    i_Psum   = d;
    while (!Psum_ack && n < 50) begin
      tick();
      n++;
    end
    if (!Psum_ack) begin
      checks++;
      errors++;
      $display("FAIL psum_timeout: got no Psum_ack expected ack within 50 cycles");
    end else begin
      tick();
    end
    Psum_rdy = 1'b0;
  endtask

  task automatic finish_job();
    int n = 0;
    while (o_busy && n < 300) begin
      tick();
      n++;
    end
    chk("drain_timeout", 64'(o_busy), 64'd0);
    done_exp++;
    chk("done_at_idle", 64'(o_done), 64'd1);
    tick();
    tick();
    chk("done_count", 64'(done_cnt), 64'(done_exp));
  endtask

  initial begin
    int l2[5] = '{0, 40, 80, 120, 127};
    int p0;
    i_rst = 1'b1; i_cfg_valid = 1'b0; i_cfg = '0; Psum_rdy = 1'b0; i_Psum = '0;
    repeat (3) tick();
    i_rst = 1'b0;
    tick();
    chk("rst_psum_ack", 64'(Psum_ack), 64'd0);
    chk("rst_out_rdy", 64'(Out_rdy), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);

    // single beat, saturation at +127
    do_cfg(mk_cfg(1, 1, 0, 0));
    chk("acc_after_cfg", 64'(Psum_ack), 64'd1);
    exp_q.push_back(mko(5, -3, 127, 127));
    send(mkp(5, -3, 127, 200));
    chk("out_rdy_latency", 64'(Out_rdy), 64'd1);
    finish_job();

    // three passes over four entries, shift by one
    do_cfg(mk_cfg(4, 3, 1, 0));
    p0 = psum_cnt;
    for (int b = 0; b < 4; b++) exp_q.push_back(mko(15, 6 * b, -11, 127));
    for (int p = 0; p < 3; p++)
      for (int b = 0; b < 4; b++) send(mkp(10, 4 * b, -7, 100));
    chk("out_rdy_latency", 64'(Out_rdy), 64'd1);
    finish_job();
    chk("psum_transfers", 64'(psum_cnt - p0), 64'd12);

    // relu with shift by two
    do_cfg(mk_cfg(1, 1, 2, 1));
    exp_q.push_back(mko(0, 100, 1, 0));
    send(mkp(-100, 400, 4, -1));
    finish_job();

    // random backpressure on drain
    ack_mode = 1;
    do_cfg(mk_cfg(5, 2, 0, 0));
    for (int i = 0; i < 5; i++) exp_q.push_back(mko(2 * i, -2 * i, l2[i], 120));
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 5; i++) send(mkp(i, -i, 20 * i, 60));
    finish_job();
    ack_mode = 0;

    // config change mid-ACC is ignored
    do_cfg(mk_cfg(3, 1, 0, 0));
    for (int i = 1; i <= 3; i++) exp_q.push_back(mko(i, 0, 0, 0));
    send(mkp(1, 0, 0, 0));
    i_cfg_valid = 1'b1;
    i_cfg       = mk_cfg(2, 1, 0, 0);
    send(mkp(2, 0, 0, 0));
    i_cfg_valid = 1'b0;
    chk("cfg_ignored_rdy", 64'(Out_rdy), 64'd0);
    chk("cfg_ignored_busy", 64'(o_busy), 64'd1);
    send(mkp(3, 0, 0, 0));
    finish_job();

    // reset during drain, then a fresh two-pass job
    ack_mode = 2;
    do_cfg(mk_cfg(2, 1, 0, 0));
    send(mkp(50, 50, 50, 50));
    send(mkp(60, 60, 60, 60));
    tick();
    tick();
    chk("drain_hold", 64'(Out_rdy), 64'd1);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    ack_mode = 0;
    chk("rst_drain_out_rdy", 64'(Out_rdy), 64'd0);
    chk("rst_drain_busy", 64'(o_busy), 64'd0);
    chk("rst_drain_done", 64'(o_done), 64'd0);
    do_cfg(mk_cfg(2, 2, 0, 0));
    exp_q.push_back(mko(2, 4, 6, 8));
    exp_q.push_back(mko(10, 12, 14, 16));
    for (int p = 0; p < 2; p++) begin
      send(mkp(1, 2, 3, 4));
      send(mkp(5, 6, 7, 8));
    end
    finish_job();

    // zero len/passes clamp to one
    do_cfg(mk_cfg(0, 0, 0, 0));
    exp_q.push_back(mko(9, 9, 9, 9));
    send(mkp(9, 9, 9, 9));
    chk("clamp_min_latency", 64'(Out_rdy), 64'd1);
    finish_job();

    // oversized len clamps to full depth
    do_cfg(mk_cfg(15, 1, 0, 0));
    for (int b = 0; b < 8; b++) exp_q.push_back(mko(b, 0, 0, 0));
    for (int b = 0; b < 8; b++) send(mkp(b, 0, 0, 0));
    chk("clamp_max_latency", 64'(Out_rdy), 64'd1);
    finish_job();

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
